// File: rtl/mem_refill_arbiter_if.sv
// rtl/mem_refill_arbiter_if.sv - requester and memory signals of mem_refill_arbiter
interface mem_refill_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST  = 4
);
  localparam int BEAT_W = $clog2(BURST);

  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy;
  logic [DATA_W-1:0] rdata;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, mem_re;

  // master: the arbiter, which owns the memory strobes
  modport master (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, beat, done0, done1, busy,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, beat, done0, done1, busy,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// rtl/mem_refill_arbiter.sv - round-robin owner of a single-ported memory for I/D-cache refills and write-throughs
module mem_refill_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_refill_arbiter_if.master bus
);
  localparam int BW = $clog2(BURST);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             state;
  logic               owner, last_grant, gnt0_q, gnt1_q, mem_we_q, mem_re_q;
  logic [ADDR_W-1:0]  base, mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [BW:0]        issue_cnt;
  logic [BW-1:0]      ret_cnt;
  logic [MEM_LAT-1:0] inflight;

  logic               any_req, pick1, sel_we, ret_valid, ret_last, fin;
  logic [ADDR_W-1:0]  sel_addr, line_addr;
  logic [DATA_W-1:0]  sel_wdata;

  assign any_req   = bus.req0 | bus.req1;
  assign pick1     = bus.req1 & (~bus.req0 | ~last_grant);
  assign sel_we    = pick1 ? bus.we1 : bus.we0;
  assign sel_addr  = pick1 ? bus.addr1 : bus.addr0;
  assign sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
  assign line_addr = sel_addr & ~ADDR_W'(BURST - 1);

  // A returning beat is only honoured while the burst that issued it is live.
  assign ret_valid = (state == READ) & inflight[MEM_LAT-1];
  assign ret_last  = ret_valid & (ret_cnt == BW'(BURST - 1));
  assign fin       = (state == WRITE) | ret_last;

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = ret_valid & ~owner;
  assign bus.rvalid1   = ret_valid & owner;
  assign bus.rdata     = ret_valid ? bus.mem_rdata : '0;
  assign bus.beat      = ret_valid ? ret_cnt : '0;
  assign bus.done0     = fin & ~owner;
  assign bus.done1     = fin & owner;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      base        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      inflight    <= '0;
    end else begin
      for (int k = MEM_LAT - 1; k > 0; k--) inflight[k] <= inflight[k-1];
      inflight[0] <= mem_re_q;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick1;
            last_grant <= pick1;
            gnt0_q     <= ~pick1;
            gnt1_q     <= pick1;
            ret_cnt    <= '0;
            if (sel_we) begin
              state       <= WRITE;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end else begin
              state      <= READ;
              base       <= line_addr;
              mem_re_q   <= 1'b1;
              mem_addr_q <= line_addr;
              issue_cnt  <= (BW+1)'(1);
            end
          end
        end
        READ: begin
          // Issue side and return side advance independently, MEM_LAT apart.
          if (!issue_cnt[BW]) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= base + ADDR_W'(issue_cnt[BW-1:0]);
            issue_cnt  <= issue_cnt + 1'b1;
          end else begin
            mem_re_q <= 1'b0;
          end
          if (ret_valid) ret_cnt <= ret_cnt + 1'b1;
          if (ret_last) begin
            state      <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        WRITE: begin
          state       <= IDLE;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Sequences and shares the single-ported backing data memory between the instruction-cache and data-cache miss handlers.
- Line refills are BURST-beat reads. Write-throughs are single-word writes.
- Round-robin arbitration between the two requesters; one transaction owns the memory at a time.
- Sits between the two cache controllers and the data memory. It replaces the memory's self-sequenced burst counter with an externally driven beat address.

Parameters:
ADDR_W, 32, address width (word addresses)
DATA_W, 32, data width
BURST, 4, beats per line refill; power of two, >= 2
MEM_LAT, 1, cycles from mem_re to valid mem_rdata; 1..3

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req0  in  1  port 0 (I-cache) request; held until done0
we0  in  1  port 0: 1 = single write, 0 = line read
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
req1, we1, addr1, wdata1  in  as port 0  port 1 (D-cache)
gnt0, gnt1  out  1  port owns the memory, level
rvalid0, rvalid1  out  1  refill beat valid for port 0 / port 1
rdata  out  DATA_W  refill beat data, shared
beat  out  log2(BURST)  index of the beat on rdata
done0, done1  out  1  one-cycle transaction complete pulse
busy  out  1  state != IDLE
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data, MEM_LAT after mem_re

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - Issue counter, return counter and the MEM_LAT-deep in-flight valid pipe are cleared.
  - last_grant = 1, so port 0 wins the first tie.
  - Reset mid-burst abandons the burst. Late mem_rdata is ignored and no rvalid/done is produced.
- States: IDLE, READ, WRITE.
- IDLE:
  - Sample req0/req1. Only one asserted: that port wins. Both asserted: the port != last_grant wins.
  - On the next edge: last_grant = winner; latch winner's we, addr, wdata; gnt<winner>=1; go to WRITE if we else READ.
  - No request: stay in IDLE, all strobes 0.
- READ:
  - Base = latched addr with low log2(BURST) bits cleared (line-aligned).
  - Issue counter i = 0..BURST-1: one beat per cycle, mem_re=1, mem_addr = base+i. After BURST issue cycles, mem_re=0.
  - Each issued beat's data returns MEM_LAT cycles later. That cycle: rvalid<winner>=1, rdata=mem_rdata, beat=return index 0..BURST-1 in order.
  - done<winner> pulses in the same cycle as the last rvalid. Next edge: gnt clears and state returns to IDLE.
  - Example, MEM_LAT=1, req at edge 0: mem_re cycles 1-4; rvalid cycles 2-5; done cycle 5; IDLE cycle 6.
- WRITE:
  - One cycle: mem_we=1, mem_addr=latched addr (not aligned), mem_wdata=latched wdata, done<winner>=1.
  - Back to IDLE next edge.
- mem_we and mem_re are never high together. Both are 0 in IDLE.
- Requester inputs (addr/we/wdata/req) are ignored after the grant edge.
  - Changes or req dropping mid-transaction have no effect; the transaction completes.
- A requester still holding req in the IDLE cycle after its done is re-arbitrated as a new request. Under round-robin the other port wins if pending.
- The non-granted port sees gnt=0, rvalid=0, done=0 throughout.
- Address arithmetic base+i is modulo 2^ADDR_W. A line at the top of the address space wraps within the line only, since base is aligned.
- Back-to-back: the earliest new grant edge is the IDLE cycle following done. Minimum one IDLE cycle between transactions.

Test Plan:
- Port 0 read, addr0=0x13, memory word[k]=k -> mem_addr 0x10,0x11,0x12,0x13 on cycles 1-4; rvalid0 beats 0-3 with rdata 0x10-0x13 on cycles 2-5; done0 cycle 5; gnt1 stays 0.
- req0 and req1 both reads raised same cycle, held through done -> port 0 served first, port 1 second, then port 0 again; grants strictly alternate.
- Port 1 write addr1=0x07, wdata1=0xDEADBEEF -> one cycle mem_we=1, mem_addr=0x07, done1=1, mem_re=0; IDLE the next cycle.
- Port 0 read in progress, req1 write arrives at beat 1 -> port 0 burst completes uninterrupted; port 1 granted on the first IDLE cycle after done0.
- rst driven low after second beat issued, then released -> outputs 0 immediately; no further rvalid/done; next req0 restarts from beat 0.
- MEM_LAT=3, port 1 read addr 0xFFFFFFFE -> mem_addr 0xFFFFFFFC..0xFFFFFFFF; rvalid1 cycles 4-7; done1 cycle 7.
